// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Duty-code type, named duty codes and the high-time helper
//               shared by the PWM generator files.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

   typedef logic [1:0] duty_code_t;

   localparam duty_code_t DUTY_0   = 2'd0;
   localparam duty_code_t DUTY_33  = 2'd1;
   localparam duty_code_t DUTY_67  = 2'd2;
   localparam duty_code_t DUTY_100 = 2'd3;

   // Number of high cycles per period for a duty code (integer truncation).
   function automatic int high_cycles(input duty_code_t code, input int period);
      int h;
      case (code)
         DUTY_0:  h = 0;
         DUTY_33: h = period / 3;
         DUTY_67: h = (2 * period) / 3;
         default: h = period;
      endcase
      return h;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_period_counter
// Description : Free-running period counter, 0..PERIOD-1, with a strobe
//               marking the final cycle of each period.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_period_counter #(
   parameter  int PERIOD = 12,
   localparam int CNT_W  = $clog2(PERIOD)
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_last_cycle
);

   logic [CNT_W-1:0] r_cnt;

   assign o_cnt        = r_cnt;
   assign o_last_cycle = (r_cnt == CNT_W'(PERIOD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (o_last_cycle) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
// Module      : pwm_generator
// Description : Fixed-period registered PWM; the 2-bit duty code is latched
//               only at period boundaries so pulses are never truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int PERIOD = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  duty_code_t duty_cycle,
   output logic       pwm_out
);

   localparam int CNT_W = $clog2(PERIOD);

   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_last_cycle;
   duty_code_t       r_duty_q;
   duty_code_t       w_duty_next;
   logic [CNT_W:0]   w_high;
   logic             w_pwm_next;

   pwm_period_counter #(
      .PERIOD       (PERIOD)
   ) u_period_counter (
      .clk          (clk),
      .reset        (reset),
      .o_cnt        (w_cnt),
      .o_last_cycle (w_last_cycle)
   );

   // Compare on next-state values so the flopped output lines up with cnt
   // without adding a cycle of latency. The extra bit in w_high holds PERIOD.
   always_comb begin
      w_cnt_next  = w_last_cycle ? '0 : w_cnt + CNT_W'(1);
      w_duty_next = w_last_cycle ? duty_cycle : r_duty_q;
      w_high      = (CNT_W + 1)'(high_cycles(w_duty_next, PERIOD));
      w_pwm_next  = ({1'b0, w_cnt_next} < w_high);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_duty_q <= DUTY_0;
         pwm_out  <= 1'b0;
      end else begin
         r_duty_q <= w_duty_next;
         pwm_out  <= w_pwm_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_generator
// Description : Self-checking bench for pwm_generator against a timeline
//               model (cycle index since reset, one duty code per period).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_generator;

   localparam int P = 12;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] duty_cycle;
   logic       pwm_out;

   int n_checks = 0;
   int n_fail   = 0;
   int t_model  = 0;
   int codes[$];

   pwm_generator #(
      .PERIOD     (P)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .duty_cycle (duty_cycle),
      .pwm_out    (pwm_out)
   );

   always #5 clk = ~clk;

   function automatic int h_ref(input int code);
      return (code * P) / 3;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, check at negedge.
   task automatic tick(input logic r, input logic [1:0] d, output logic p);
      int pos;
      int exp_pwm;
      reset      = r;
      duty_cycle = d;
      @(posedge clk);
      if (r) begin
         t_model = 0;
         codes.delete();
         codes.push_back(0);
      end else begin
         if (t_model % P == P - 1) codes.push_back(int'(d));
         t_model++;
      end
      @(negedge clk);
      pos     = t_model % P;
      exp_pwm = (pos < h_ref(codes[t_model / P])) ? 1 : 0;
      check_eq("pwm", 32'(pwm_out), exp_pwm);
      check_eq("cnt", 32'(dut.w_cnt), pos);
      p = pwm_out;
   endtask

   task automatic run_cycles(input int n, input logic [1:0] d, output int highs);
      logic p;
      highs = 0;
      for (int i = 0; i < n; i++) begin
         tick(1'b0, d, p);
         if (p === 1'b1) highs++;
      end
   endtask

   task automatic align(input logic [1:0] d);
      logic p;
      int   guard;
      guard = 0;
      while ((t_model % P != P - 1) && guard < P) begin
         tick(1'b0, d, p);
         guard++;
      end
      check_eq("align", t_model % P, P - 1);
   endtask

   initial begin
      logic       p;
      int         h;
      int         h2;
      logic [1:0] d;
      logic       r;
      codes.push_back(0);

      // Reset hold with code 3 applied
      tick(1'b1, 2'd3, p);
      tick(1'b1, 2'd3, p);
      check_eq("reset_pwm", 32'(p), 0);
      run_cycles(P - 1, 2'd3, h);
      check_eq("first_period_low", h, 0);

      // Code 3 over two wraps, then 3->0
      run_cycles(P, 2'd3, h);
      check_eq("code3_period_a", h, P);
      run_cycles(P, 2'd3, h);
      check_eq("code3_period_b", h, P);
      run_cycles(P, 2'd0, h);
      check_eq("code0_after_3", h, 0);
      run_cycles(30, 2'd0, h);
      check_eq("code0_30cyc", h, 0);

      // Code 2 then code 1
      align(2'd2);
      run_cycles(P, 2'd2, h);
      check_eq("code2_period", h, 8);
      run_cycles(P, 2'd1, h);
      check_eq("code1_period", h, 4);

      // Mid-period change 2->1 at cnt=5
      run_cycles(6, 2'd2, h);
      run_cycles(6, 2'd1, h2);
      check_eq("midchange_cur", h + h2, 8);
      run_cycles(P, 2'd1, h);
      check_eq("midchange_next", h, 4);

      // 0->3 transition
      run_cycles(P, 2'd0, h);
      check_eq("code0_before3", h, 0);
      run_cycles(P, 2'd3, h);
      check_eq("code3_after0", h, P);

      // Reset mid-period at cnt=3 with code 3
      run_cycles(3, 2'd3, h);
      check_eq("pre_reset_high", h, 3);
      tick(1'b1, 2'd3, p);
      check_eq("midreset_pwm", 32'(p), 0);
      run_cycles(P - 1, 2'd3, h);
      check_eq("post_reset_low", h, 0);

      // Randomized phase with occasional resets and sticky duty codes
      d = 2'($urandom_range(0, 3));
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) d = 2'($urandom_range(0, 3));
         r = ($urandom_range(0, 59) == 0);
         tick(r, d, p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
